// File: rtl/mix_tree_pkg.sv
// mix_tree_pkg: shared state encoding and sizing helpers for the mixing-tree scheduler
package mix_tree_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_MIX, S_XFER, S_DISP, S_DONE} state_e;
  function automatic int lvl_w(input int levels);
    return levels > 1 ? $clog2(levels) : 1;
  endfunction
  function automatic int timer_w(input int fill, input int mix, input int xfer);
    int mx;
    mx = fill > mix ? fill : mix;
    mx = mx > xfer ? mx : xfer;
    return mx > 1 ? $clog2(mx) : 1;
  endfunction
  function automatic int busy_cycles(input int levels, input int fill, input int mix, input int xfer);
    return fill + levels * mix + levels * xfer;
  endfunction
endpackage

// File: rtl/mix_tree_scheduler_phase_timer.sv
// phase_timer: loadable down-counter (clk, rst_n, load, val in; expired out when count is 0)
module phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         expired
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= load ? val : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  end
  assign expired = cnt_q == '0;
endmodule

// File: rtl/mix_tree_scheduler.sv
// mix_tree_scheduler: sequences fill/mix/transfer/dispense valves of a binary mixing tree (start/abort/inlet_mask in; valve enables, level, busy/done/err out)
import mix_tree_pkg::*;
module mix_tree_scheduler #(
  parameter int LEVELS      = 4,
  parameter int FILL_CYCLES = 8,
  parameter int MIX_CYCLES  = 16,
  parameter int XFER_CYCLES = 4,
  localparam int N  = 2 ** LEVELS,
  localparam int LW = lvl_w(LEVELS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [N-1:0]      inlet_mask,
  output logic [N-1:0]      inlet_open,
  output logic [LEVELS-1:0] mix_en,
  output logic [LEVELS-1:0] xfer_en,
  output logic              outlet_open,
  output logic [LW-1:0]     level,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int TW = timer_w(FILL_CYCLES, MIX_CYCLES, XFER_CYCLES);
  localparam logic [TW-1:0] T_FILL = TW'(FILL_CYCLES - 1);
  localparam logic [TW-1:0] T_MIX  = TW'(MIX_CYCLES - 1);
  localparam logic [TW-1:0] T_XFER = TW'(XFER_CYCLES - 1);
  state_e state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic [N-1:0] mask_q, mask_d;
  logic [TW-1:0] ld_val;
  logic ld, expired, err_d, run;
  assign run = state_q inside {S_FILL, S_MIX, S_XFER, S_DISP};
  phase_timer #(.W(TW)) u_timer (
    .clk(clk), .rst_n(rst_n), .load(ld), .val(ld_val), .expired(expired)
  );
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    mask_d = mask_q;
    ld = 1'b0;
    ld_val = '0;
    err_d = 1'b0;
    if (run && abort) begin
      state_d = S_IDLE;
      level_d = '0;
      ld = 1'b1;
      err_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (start && !abort) begin
          if (inlet_mask != '0) begin
            state_d = S_FILL;
            mask_d = inlet_mask;
            ld = 1'b1;
            ld_val = T_FILL;
          end else err_d = 1'b1;
        end
        S_FILL: if (expired) begin
          state_d = S_MIX;
          level_d = LW'(LEVELS - 1);
          ld = 1'b1;
          ld_val = T_MIX;
        end
        S_MIX: if (expired) begin
          state_d = level_q == '0 ? S_DISP : S_XFER;
          ld = 1'b1;
          ld_val = T_XFER;
        end
        S_XFER: if (expired) begin
          state_d = S_MIX;
          level_d = level_q - 1'b1;
          ld = 1'b1;
          ld_val = T_MIX;
        end
        S_DISP: if (expired) begin
          state_d = S_DONE;
          ld = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      level_q <= '0;
      mask_q <= '0;
      inlet_open <= '0;
      mix_en <= '0;
      xfer_en <= '0;
      outlet_open <= 1'b0;
      level <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      mask_q <= mask_d;
      inlet_open <= state_d == S_FILL ? mask_d : '0;
      mix_en <= state_d == S_MIX ? LEVELS'(1) << level_d : '0;
      xfer_en <= state_d == S_XFER ? LEVELS'(1) << level_d : '0;
      outlet_open <= state_d == S_DISP;
      level <= state_d inside {S_MIX, S_XFER} ? level_d : '0;
      busy <= state_d inside {S_FILL, S_MIX, S_XFER, S_DISP};
      done <= state_d == S_DONE;
      err <= err_d;
    end
  end
endmodule

// File: tb/tb_mix_tree_scheduler.sv
// tb_mix_tree_scheduler: table vectors plus scoreboarded full-run sequences for mix_tree_scheduler
import mix_tree_pkg::*;
module tb_mix_tree_scheduler;
  localparam int L = 4, F = 8, M = 16, X = 4;
  localparam int TOTAL = busy_cycles(L, F, M, X);
  typedef struct packed {
    logic [15:0] inl;
    logic [3:0] mix;
    logic [3:0] xf;
    logic outl;
    logic [1:0] lvl;
    logic busy;
    logic done;
    logic err;
  } exp_t;
  typedef struct {
    logic r;
    logic s;
    logic a;
    logic [15:0] m;
    exp_t e;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n, start, abort;
  logic [15:0] inlet_mask, inlet_open;
  logic [3:0] mix_en, xfer_en;
  logic outlet_open, busy, done, err;
  logic [1:0] level;
  int total = 0, bad = 0, bc = 0, k = 0, cyc = 0;
  logic [15:0] ml = '0;
  exp_t q[$];
  exp_t ee, aa;
  vec_t tbl[9];
  mix_tree_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .inlet_mask(inlet_mask),
    .inlet_open(inlet_open), .mix_en(mix_en), .xfer_en(xfer_en), .outlet_open(outlet_open),
    .level(level), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  function automatic exp_t exp_for(input int kk, input logic [15:0] m);
    exp_t e = '0;
    int t, lev, r;
    if (kk >= 1 && kk <= F) begin
      e.inl = m;
      e.busy = 1'b1;
    end else if (kk > F && kk <= TOTAL) begin
      t = kk - F - 1;
      lev = L - 1 - t / (M + X);
      r = t % (M + X);
      e.busy = 1'b1;
      if (r < M) begin
        e.mix = 4'(1 << lev);
        e.lvl = 2'(lev);
      end else if (lev > 0) begin
        e.xf = 4'(1 << lev);
        e.lvl = 2'(lev);
      end else e.outl = 1'b1;
    end else if (kk == TOTAL + 1) e.done = 1'b1;
    return e;
  endfunction
  function automatic exp_t idle_err(input logic er);
    exp_t e = '0;
    e.err = er;
    return e;
  endfunction
  task automatic drive(input logic r, input logic s, input logic a, input logic [15:0] m, input exp_t e);
    rst_n = r;
    start = s;
    abort = a;
    inlet_mask = m;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic tick(input logic s, input logic a, input logic [15:0] m);
    exp_t e;
    if (k == 0) begin
      if (s && !a && m != '0) begin
        k = 1;
        ml = m;
        e = exp_for(1, ml);
      end else e = idle_err(s && !a && m == '0);
    end else if (k <= TOTAL && a) begin
      k = 0;
      e = idle_err(1'b1);
    end else if (k == TOTAL + 1) begin
      k = 0;
      e = '0;
    end else begin
      k++;
      e = exp_for(k, ml);
    end
    drive(1'b1, s, a, m, e);
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      cyc++;
      ee = q.pop_front();
      aa = {inlet_open, mix_en, xfer_en, outlet_open, level, busy, done, err};
      total++;
      if (aa !== ee) begin
        bad++;
        $display("FAIL outputs cyc=%0d got inl=%h mix=%b xf=%b out=%b lvl=%0d busy=%b done=%b err=%b want inl=%h mix=%b xf=%b out=%b lvl=%0d busy=%b done=%b err=%b",
          cyc, aa.inl, aa.mix, aa.xf, aa.outl, aa.lvl, aa.busy, aa.done, aa.err,
          ee.inl, ee.mix, ee.xf, ee.outl, ee.lvl, ee.busy, ee.done, ee.err);
      end
      total++;
      if ($countones({|inlet_open, |mix_en, |xfer_en, outlet_open}) > 1) begin
        bad++;
        $display("FAIL valve_safety cyc=%0d got inl=%h mix=%b xf=%b out=%b want at most one group open",
          cyc, inlet_open, mix_en, xfer_en, outlet_open);
      end
      if (busy === 1'b1) bc++;
      if (done === 1'b1) begin
        total++;
        if (bc != TOTAL) begin
          bad++;
          $display("FAIL busy_length got %0d want %0d", bc, TOTAL);
        end
        bc = 0;
      end
      if (err === 1'b1) bc = 0;
    end
  end
  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b0, 16'hFFFF, idle_err(1'b0)};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 16'hFFFF, idle_err(1'b0)};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 16'hFFFF, idle_err(1'b0)};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 16'hFFFF, idle_err(1'b0)};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 16'hFFFF, idle_err(1'b0)};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 16'h0000, idle_err(1'b1)};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 16'h0000, idle_err(1'b0)};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 16'hFFFF, idle_err(1'b0)};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 16'hFFFF, idle_err(1'b0)};
    for (int i = 0; i < 9; i++) drive(tbl[i].r, tbl[i].s, tbl[i].a, tbl[i].m, tbl[i].e);
    tick(1'b1, 1'b0, 16'hFFFF);
    for (int i = 2; i <= 92; i++) tick(i == 40, 1'b0, i == 40 ? 16'h0000 : 16'hFFFF);
    tick(1'b1, 1'b0, 16'h00F3);
    for (int i = 2; i <= 92; i++) tick(1'b0, i == 90, i >= 3 ? 16'hFFFF : 16'h00F3);
    tick(1'b1, 1'b0, 16'hFFFF);
    for (int i = 2; i <= 31; i++) tick(1'b0, i == 31, 16'hFFFF);
    tick(1'b0, 1'b0, 16'hFFFF);
    tick(1'b0, 1'b0, 16'hFFFF);
    tick(1'b1, 1'b0, 16'h0F0F);
    for (int i = 2; i <= 92; i++) tick(1'b0, 1'b0, 16'hFFFF);
    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
